fpga_board_io_ctrl: RTL and testbench

- Parametrised board-level I/O conditioning block for the FPGA targets; sits between the board pins (buttons, switches, LEDs) and the SoC pad_io/GPIO signals.
- Each board input is synchronised and debounced, and produces a stable level plus single-cycle rise and fall pulses.
- Each LED is driven by a per-channel mode: off, on, blink or PWM. This replaces fixed one-to-one pin mapping with conditioned, configurable I/O.

---
 rtl/fpga_board_io_pkg.sv | 18 +
 rtl/io_debounce.sv | 60 ++++++
 rtl/fpga_board_io_ctrl.sv | 91 +++++++++
 tb/tb_fpga_board_io_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fpga_board_io_pkg.sv
// Shared types and default parameter values for the board I/O conditioning block.
package fpga_board_io_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_e;

  localparam int unsigned DEF_NUM_IN          = 7;
  localparam int unsigned DEF_NUM_LED         = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 100000;
  localparam int unsigned DEF_PWM_WIDTH       = 8;
  localparam int unsigned DEF_BLINK_CYCLES    = 5000000;

endpackage

// File: rtl/io_debounce.sv
// One board input channel: synchroniser chain, debounce counter and
// single-cycle rise/fall pulses aligned with the stable-level update.
module io_debounce
  import fpga_board_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability chain: bit 0 samples the raw pad, the top bit is the synced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Accept a new level only after it persists; any reversion restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced != level) begin
        if (cnt_q == CNT_LAST) begin
          level <= synced;
          rise  <= synced;
          fall  <= ~synced;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/fpga_board_io_ctrl.sv
// Board I/O conditioning: debounced inputs with edge pulses, and per-LED
// off/on/blink/PWM drive from shared free-running counters.
module fpga_board_io_ctrl
  import fpga_board_io_pkg::*;
#(
  parameter int unsigned NUM_IN          = DEF_NUM_IN,
  parameter int unsigned NUM_LED         = DEF_NUM_LED,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PWM_WIDTH       = DEF_PWM_WIDTH,
  parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_IN-1:0]              pad_in_i,
  output logic [NUM_IN-1:0]              in_level_o,
  output logic [NUM_IN-1:0]              in_rise_o,
  output logic [NUM_IN-1:0]              in_fall_o,
  input  logic [2*NUM_LED-1:0]           led_mode_i,
  input  logic [PWM_WIDTH*NUM_LED-1:0]   led_duty_i,
  output logic [NUM_LED-1:0]             led_o
);

  localparam int unsigned   BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [BW-1:0]        blink_cnt_q;
  logic                 blink_phase_q;
  logic [NUM_LED-1:0]   led_d;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .pad   (pad_in_i[g]),
      .level (in_level_o[g]),
      .rise  (in_rise_o[g]),
      .fall  (in_fall_o[g])
    );
  end

  // Shared PWM timebase, wraps naturally at 2^PWM_WIDTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
    end
  end

  // Shared blink timebase; phase toggles each half-period so all blinking LEDs stay aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BW'(1);
    end
  end

  // Per-LED mode selection.
  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      case (led_mode_e'(led_mode_i[2*i +: 2]))
        LED_OFF:   led_d[i] = 1'b0;
        LED_ON:    led_d[i] = 1'b1;
        LED_BLINK: led_d[i] = blink_phase_q;
        LED_PWM:   led_d[i] = (pwm_cnt_q < led_duty_i[PWM_WIDTH*i +: PWM_WIDTH]);
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_o <= '0;
    end else begin
      led_o <= led_d;
    end
  end

endmodule

// File: tb/tb_fpga_board_io_ctrl.sv
// Directed self-checking bench for fpga_board_io_ctrl (SYNC=2, DEBOUNCE=4, PWM=8, BLINK=10).
module tb_fpga_board_io_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  pad_in;
  logic [6:0]  in_level;
  logic [6:0]  in_rise;
  logic [6:0]  in_fall;
  logic [7:0]  led_mode;
  logic [31:0] led_duty;
  logic [3:0]  led;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fpga_board_io_ctrl #(
    .NUM_IN          (7),
    .NUM_LED         (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .PWM_WIDTH       (8),
    .BLINK_CYCLES    (10)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pad_in_i   (pad_in),
    .in_level_o (in_level),
    .in_rise_o  (in_rise),
    .in_fall_o  (in_fall),
    .led_mode_i (led_mode),
    .led_duty_i (led_duty),
    .led_o      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned hi_cnt;
    logic        b1;
    logic [7:0]  duties [4];
    duties[0] = 8'd64; duties[1] = 8'd0; duties[2] = 8'd255; duties[3] = 8'd128;

    // Reset with all pads high, LED1 blinking
    rst_n    = 1'b0;
    pad_in   = 7'h7F;
    led_mode = 8'b0000_1000;
    led_duty = '0;
    tick(3);
    check("rst_level", 32'(in_level), 32'h0);
    check("rst_rise",  32'(in_rise),  32'h0);
    check("rst_fall",  32'(in_fall),  32'h0);
    check("rst_led",   32'(led),      32'h0);

    // Release: level after 6 edges, single rise; blink low for 10 cycles then toggles every 10
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      check($sformatf("rel_level_k%0d", k), 32'(in_level), (k >= 6) ? 32'h7F : 32'h0);
      check($sformatf("rel_rise_k%0d", k),  32'(in_rise),  (k == 6) ? 32'h7F : 32'h0);
      check($sformatf("rel_fall_k%0d", k),  32'(in_fall),  32'h0);
      b1 = (k <= 10) ? 1'b0 : ((((k - 11) / 10) % 2) == 0);
      check($sformatf("blink_k%0d", k), 32'(led), b1 ? 32'h2 : 32'h0);
    end

    // Mode changes take effect one cycle after the input change
    led_mode = 8'b0001_1000;
    tick(1);
    check("mode_led2_on", 32'(led), 32'h4);
    led_mode = 8'b0000_0100;
    check("mode_before_edge", 32'(led), 32'h4);
    tick(1);
    check("mode_after_edge", 32'(led), 32'h2);

    // Channel 0 falls: level drops 6 edges later with one fall pulse
    pad_in = 7'h7E;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("fall_level_k%0d", k), 32'(in_level), (k >= 6) ? 32'h7E : 32'h7F);
      check($sformatf("fall_pulse_k%0d", k), 32'(in_fall),  (k == 6) ? 32'h01 : 32'h0);
      check($sformatf("fall_rise_k%0d", k),  32'(in_rise),  32'h0);
    end

    // Channel 0 high for only 3 cycles: rejected
    pad_in = 7'h7F;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check($sformatf("short_hi_level_k%0d", k), 32'(in_level), 32'h7E);
    end
    pad_in = 7'h7E;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("short_lo_level_k%0d", k), 32'(in_level), 32'h7E);
      check($sformatf("short_lo_rise_k%0d", k),  32'(in_rise),  32'h0);
    end

    // 1-0-1 bounce then steady high: rise 6 edges after the last 0->1
    pad_in = 7'h7F;
    tick(1);
    check("bounce_a", 32'(in_level), 32'h7E);
    pad_in = 7'h7E;
    tick(1);
    check("bounce_b", 32'(in_level), 32'h7E);
    pad_in = 7'h7F;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("bounce_level_k%0d", k), 32'(in_level), (k >= 6) ? 32'h7F : 32'h7E);
      check($sformatf("bounce_rise_k%0d", k),  32'(in_rise),  (k == 6) ? 32'h01 : 32'h0);
    end

    // Reset during a pending rise (counter==2), then full latency restarts
    pad_in = 7'h7E;
    tick(8);
    check("pre_mid_level", 32'(in_level), 32'h7E);
    pad_in = 7'h7F;
    tick(4);
    check("mid_pending_level", 32'(in_level), 32'h7E);
    check("mid_led_on", 32'(led), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(in_level), 32'h0);
    check("mid_rst_rise",  32'(in_rise),  32'h0);
    check("mid_rst_fall",  32'(in_fall),  32'h0);
    check("mid_rst_led",   32'(led),      32'h0);
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("rerel_level_k%0d", k), 32'(in_level), (k >= 6) ? 32'h7F : 32'h0);
      check($sformatf("rerel_rise_k%0d", k),  32'(in_rise),  (k == 6) ? 32'h7F : 32'h0);
      check($sformatf("rerel_fall_k%0d", k),  32'(in_fall),  32'h0);
    end

    // PWM on LED0: high-cycle count over 256 cycles equals duty
    led_mode = 8'b0000_0111;
    for (int d = 0; d < 4; d++) begin
      led_duty = {24'h0, duties[d]};
      hi_cnt = 0;
      for (int c = 0; c < 256; c++) begin
        tick(1);
        hi_cnt += 32'(led[0]);
      end
      check($sformatf("pwm_duty_%0d", duties[d]), hi_cnt, 32'(duties[d]));
      check($sformatf("pwm_led1_on_%0d", duties[d]), 32'(led[1]), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
